mips_exec_arith: RTL and testbench
==================================

// Module: mips_exec_arith
// PURPOSE
//  Arithmetic/sequencing slice of the single-cycle MIPS core: a 32-bit ALU, a
//  32-bit address adder (PC+4 and branch-target computation) and a 2-bit
//  free-running scan counter for the 4-digit 7-segment display multiplexer.
//  ALU and adder are purely combinational; only the scan counter is clocked.
// PARAMETERS
//  WIDTH      32  datapath width of ALU and adder
//  CNT_WIDTH  2   scan counter width (4 display digits)
// PORTS
//  clk         in   1      system clock, rising-edge active
//  rst_n       in   1      asynchronous reset, active low
//  add_a       in   WIDTH  adder operand A
//  add_b       in   WIDTH  adder operand B
//  add_sum     out  WIDTH  add_a + add_b, modulo 2^WIDTH
//  alu_a       in   WIDTH  ALU operand A (register rs)
//  alu_b       in   WIDTH  ALU operand B (rt or sign-extended immediate)
//  alu_op      in   4      ALU operation select
//  alu_result  out  WIDTH  ALU result
//  alu_zero    out  1      1 when alu_result == 0
//  cnt_out     out  CNT_WIDTH  display digit-select count
// BEHAVIOUR
//  Clock/reset: one clock domain. rst_n low asynchronously forces cnt_out=0;
//   the count holds at 0 while rst_n is low; first increment on the first
//   rising clk edge after rst_n deasserts. ALU/adder ignore clk and rst_n.
//  Adder: add_sum = add_a + add_b, zero latency; carry-out is discarded
//   (0xFFFFFFFC + 4 = 0x00000000).
//  ALU (combinational, zero latency), alu_op encoding:
//   0000 AND   a & b
//   0001 OR    a | b
//   0010 ADD   a + b, wrap, no overflow trap
//   0011 XOR   a ^ b
//   0100 SLL   b << a[4:0]
//   0101 SRL   b >> a[4:0] (logical)
//   0110 SUB   a - b, wrap, no overflow trap
//   0111 SLT   signed a < b ? 1 : 0
//   1000 SLTU  unsigned a < b ? 1 : 0
//   1001 SRA   $signed(b) >>> a[4:0]
//   1100 NOR   ~(a | b)
//   others     result 0 (hence alu_zero=1); no X propagation
//  Shift amounts use only a[4:0]; a[31:5] ignored for shifts.
//  alu_zero is derived from alu_result for every op (BEQ uses SUB + zero).
//  SLT/SLTU results are 0x00000000 or 0x00000001 exactly.
//  Scan counter: cnt_out increments by 1 every rising clk edge,
//   sequence 0,1,2,3,0,... wrapping 3->0 with no stall; no enable input.
//  Reset mid-count: asynchronous return to 0 immediately, independent of clk.
//  No outputs are registered other than cnt_out; no internal state besides it.
// TESTING
//  Adder: add_a=0x00000000,add_b=4 -> 0x4; 0xFFFFFFFC+4 -> 0x00000000 (wrap).
//  ALU arith: a=7,b=5: ADD->12, SUB->2 zero=0; a=b=0x1234 SUB->0, zero=1.
//  ALU compare: a=0xFFFFFFFF,b=1: SLT->1, SLTU->0; a=1,b=0xFFFFFFFF: SLT->0, SLTU->1.
//  ALU logic/shift: a=0xF0F0F0F0,b=0x0FF00FF0: AND->0x00F000F0, OR->0xFFF0FFF0,
//   NOR->0x000F000F; a=4,b=0x80000000: SLL->0, SRL->0x08000000, SRA->0xF8000000;
//   alu_op=1111 -> 0, zero=1.
//  Counter: release rst_n, 6 clk edges -> 1,2,3,0,1,2; assert rst_n between
//   edges while count=2 -> 0 immediately without a clk edge.
//  Reset hold: rst_n low for 5 clk edges -> cnt_out stays 0 throughout.

Source files
------------

// File: rtl/mips_exec_arith.sv
`default_nettype none
// ============================================================================
//  Module      : mips_exec_arith
//  Description : Arithmetic/sequencing slice of the single-cycle MIPS core.
//                Combinational 32-bit ALU, combinational address adder
//                (PC+4 / branch target) and a free-running display scan
//                counter, which is the only clocked state.
//  Revision    : 1.0  initial release
// ============================================================================
module mips_exec_arith #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     add_a,
  input  logic [WIDTH-1:0]     add_b,
  output logic [WIDTH-1:0]     add_sum,
  input  logic [WIDTH-1:0]     alu_a,
  input  logic [WIDTH-1:0]     alu_b,
  input  logic [3:0]           alu_op,
  output logic [WIDTH-1:0]     alu_result,
  output logic                 alu_zero,
  output logic [CNT_WIDTH-1:0] cnt_out
);

  // ALU operation encodings
  localparam logic [3:0] c_op_and  = 4'b0000;
  localparam logic [3:0] c_op_or   = 4'b0001;
  localparam logic [3:0] c_op_add  = 4'b0010;
  localparam logic [3:0] c_op_xor  = 4'b0011;
  localparam logic [3:0] c_op_sll  = 4'b0100;
  localparam logic [3:0] c_op_srl  = 4'b0101;
  localparam logic [3:0] c_op_sub  = 4'b0110;
  localparam logic [3:0] c_op_slt  = 4'b0111;
  localparam logic [3:0] c_op_sltu = 4'b1000;
  localparam logic [3:0] c_op_sra  = 4'b1001;
  localparam logic [3:0] c_op_nor  = 4'b1100;

  localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Shift amount comes from the low five bits of operand A only
  logic [4:0]           w_shamt;
  logic                 w_lt_signed;
  logic                 w_lt_unsigned;
  logic [WIDTH-1:0]     w_result;
  logic [CNT_WIDTH-1:0] r_cnt;

  assign w_shamt       = alu_a[4:0];
  assign w_lt_signed   = ($signed(alu_a) < $signed(alu_b));
  assign w_lt_unsigned = (alu_a < alu_b);

  // Address adder: carry-out is simply dropped so PC arithmetic wraps
  assign add_sum = add_a + add_b;

  // ALU operation decode; unused encodings give zero so nothing goes X
  always_comb begin
    w_result = '0;
    case (alu_op)
      c_op_and:  w_result = alu_a & alu_b;
      c_op_or:   w_result = alu_a | alu_b;
      c_op_add:  w_result = alu_a + alu_b;
      c_op_xor:  w_result = alu_a ^ alu_b;
      c_op_sll:  w_result = alu_b << w_shamt;
      c_op_srl:  w_result = alu_b >> w_shamt;
      c_op_sub:  w_result = alu_a - alu_b;
      c_op_slt:  w_result = {{(WIDTH-1){1'b0}}, w_lt_signed};
      c_op_sltu: w_result = {{(WIDTH-1){1'b0}}, w_lt_unsigned};
      c_op_sra:  w_result = $signed(alu_b) >>> w_shamt;
      c_op_nor:  w_result = ~(alu_a | alu_b);
      default:   w_result = '0;
    endcase
  end

  assign alu_result = w_result;
  // Zero flag follows the result for every op so BEQ/BNE can use SUB
  assign alu_zero   = (w_result == '0);

  // Free-running digit-select counter, wraps naturally at 2^CNT_WIDTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cnt_one;
    end
  end

  assign cnt_out = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mips_exec_arith.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_exec_arith
//  Description : Self-checking bench for mips_exec_arith: directed corner
//                vectors, randomized ALU/adder vectors against an arithmetic
//                reference model, and scan counter / async reset sequencing.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_exec_arith;

  logic        clk;
  logic        rst_n;
  logic [31:0] add_a, add_b, add_sum;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_zero;
  logic [1:0]  cnt_out;

  int n_vec;
  int n_err;

  mips_exec_arith #(.WIDTH(32), .CNT_WIDTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sum    (add_sum),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .cnt_out    (cnt_out)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference ALU in plain integer arithmetic on 64-bit values
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb, p, r;
    int     sh;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(a % 32);
    p  = 1;
    for (int i = 0; i < sh; i++) p = p * 2;
    r  = 0;
    case (op)
      4'd0:  r = longint'({32'd0, a & b});
      4'd1:  r = longint'({32'd0, a | b});
      4'd2:  r = (ua + ub) % 64'sh1_0000_0000;
      4'd3:  r = longint'({32'd0, a ^ b});
      4'd4:  r = (ub * p) % 64'sh1_0000_0000;
      4'd5:  r = ub / p;
      4'd6:  r = (ua - ub + 64'sh1_0000_0000) % 64'sh1_0000_0000;
      4'd7:  r = (sa < sb) ? 1 : 0;
      4'd8:  r = (ua < ub) ? 1 : 0;
      4'd9:  r = (sb >= 0) ? (sb / p) : -((-sb + p - 1) / p);
      4'd12: r = longint'({32'd0, ~(a | b)});
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic alu_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] zexp;
    alu_op = op; alu_a = a; alu_b = b;
    #1;
    zexp = (exp == 32'd0) ? 32'd1 : 32'd0;
    check(tag, alu_result, exp);
    check({tag, "_zero"}, {31'd0, alu_zero}, zexp);
  endtask

  task automatic add_vec(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    add_a = a; add_b = b;
    #1;
    check(tag, add_sum, exp);
  endtask

  initial begin
    logic [31:0] a, b, e;
    logic [3:0]  op;
    longint      s;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0;
    add_a = '0; add_b = '0; alu_a = '0; alu_b = '0; alu_op = '0;
    #1;
    check("cnt_reset", {30'd0, cnt_out}, 32'd0);

    // Directed corner vectors
    add_vec("add_pc4",  32'h0000_0000, 32'd4, 32'h0000_0004);
    add_vec("add_wrap", 32'hFFFF_FFFC, 32'd4, 32'h0000_0000);
    alu_vec("add_7_5",  4'b0010, 32'd7, 32'd5, 32'd12);
    alu_vec("sub_7_5",  4'b0110, 32'd7, 32'd5, 32'd2);
    alu_vec("sub_eq",   4'b0110, 32'h1234, 32'h1234, 32'd0);
    alu_vec("slt_m1_1", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_vec("sltu_m1_1",4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_vec("slt_1_m1", 4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0);
    alu_vec("sltu_1_m1",4'b1000, 32'd1, 32'hFFFF_FFFF, 32'd1);
    alu_vec("and_pat",  4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
    alu_vec("or_pat",   4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
    alu_vec("nor_pat",  4'b1100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h000F_000F);
    alu_vec("xor_pat",  4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
    alu_vec("sll_4",    4'b0100, 32'd4, 32'h8000_0000, 32'h0000_0000);
    alu_vec("srl_4",    4'b0101, 32'd4, 32'h8000_0000, 32'h0800_0000);
    alu_vec("sra_4",    4'b1001, 32'd4, 32'h8000_0000, 32'hF800_0000);
    alu_vec("sll_hi_a", 4'b0100, 32'hFFFF_FFE1, 32'h0000_0001, 32'h0000_0002);
    alu_vec("op_1111",  4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0);
    alu_vec("op_1010",  4'b1010, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0);

    // Randomized ALU and adder vectors
    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if (i % 4 == 0) b = a;                  // exercise equality / zero flag
      if (i % 5 == 1) a = 32'($urandom_range(0, 31)) | (a & 32'hFFFF_FFE0);
      e = ref_alu(op, a, b);
      alu_vec($sformatf("rnd_alu_op%0d", op), op, a, b, e);
      s = (longint'({32'd0, a}) + longint'({32'd0, b})) % 64'sh1_0000_0000;
      add_vec("rnd_add", a, b, s[31:0]);
    end

    // Scan counter: release reset between edges, then count 1,2,3,0,1,2
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("cnt_seq%0d", i), {30'd0, cnt_out}, 32'(i % 4));
    end
    // Count is 2 here; asynchronous reset must clear it with no clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("cnt_async_rst", {30'd0, cnt_out}, 32'd0);
    // Held in reset across several edges
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("cnt_hold%0d", i), {30'd0, cnt_out}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("cnt_release", {30'd0, cnt_out}, 32'd0);
    @(posedge clk);
    #1;
    check("cnt_first_inc", {30'd0, cnt_out}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
